mux_arb_mto1: RTL and testbench

//  Registered M-input, N-bit mux with per-input valid/ready handshake and packet locking.

---
 rtl/mux_arb_mto1.sv | 135 +++++++++++++
 tb/tb_mux_arb_mto1.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_mto1.sv
// Registered M-to-1 valid/ready mux with packet locking.
// The input is chosen by an external select or by round-robin, and the grant holds until that packet's last beat.
module mux_arb_mto1 #(
    parameter int N        = 8,
    parameter int M        = 4,
    parameter int S        = 2,
    parameter int ARB_MODE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M*N-1:0] in_data,
    input  logic [M-1:0]   in_valid,
    input  logic [M-1:0]   in_last,
    output logic [M-1:0]   in_ready,
    input  logic [S-1:0]   sel,
    output logic [N-1:0]   out_data,
    output logic           out_valid,
    output logic           out_last,
    output logic [S-1:0]   out_sel,
    input  logic           out_ready
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t       state_q, state_d;
    logic [S-1:0] gnt_q, gnt_d;
    logic [S-1:0] ptr_q, ptr_d;
    logic [N-1:0] outData_q, outData_d;
    logic         outValid_q, outValid_d;
    logic         outLast_q, outLast_d;
    logic [S-1:0] outSel_q, outSel_d;

    logic         candValid;
    logic [S-1:0] candIdx;
    logic [N-1:0] candData;
    logic         candLast;
    logic         space;
    logic         xfer;

    assign space = !outValid_q || out_ready;

    // In LOCK the grant is pinned; in IDLE the candidate comes from sel or a wrapping search from ptr.
    always_comb begin
        candValid = 1'b0;
        candIdx   = '0;
        if (state_q == LOCK) begin
            candValid = 1'b1;
            candIdx   = gnt_q;
        end else if (ARB_MODE == 0) begin
            for (int k = 0; k < M; k++) begin
                if (sel == S'(k) && in_valid[k]) begin
                    candValid = 1'b1;
                    candIdx   = S'(k);
                end
            end
        end else begin
            for (int i = 0; i < M; i++) begin
                for (int k = 0; k < M; k++) begin
                    if (!candValid && k == (int'(ptr_q) + i) % M && in_valid[k]) begin
                        candValid = 1'b1;
                        candIdx   = S'(k);
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        candData = '0;
        candLast = 1'b0;
        for (int k = 0; k < M; k++) begin
            if (candIdx == S'(k)) begin
                in_ready[k] = space && candValid && !rst;
                candData    = in_data[N*k +: N];
                candLast    = in_last[k];
            end
        end
    end

    assign xfer = |(in_ready & in_valid);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        outSel_d   = outSel_q;
        if (xfer) begin
            outData_d  = candData;
            outLast_d  = candLast;
            outSel_d   = candIdx;
            outValid_d = 1'b1;
            if (candLast) begin
                state_d = IDLE;
                if (ARB_MODE == 1) begin
                    ptr_d = (candIdx == S'(M-1)) ? '0 : candIdx + S'(1);
                end
            end else begin
                state_d = LOCK;
                gnt_d   = candIdx;
            end
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outSel_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            outSel_q   <= outSel_d;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign out_last  = outLast_q;
    assign out_sel   = outSel_q;

endmodule

// File: tb/tb_mux_arb_mto1.sv
// Bench for mux_arb_mto1: a fixed-select instance (S=3) and a round-robin instance side by side,
// fed from per-input beat queues and checked against a scoreboard of expected output beats.
module tb_mux_arb_mto1;
    localparam int N = 8;
    localparam int M = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [M*N-1:0] fData, rData;
    logic [M-1:0]   fValid, fLast, fReady, rValid, rLast, rReady;
    logic [2:0]     fSel, fOutSel;
    logic [1:0]     rSel, rOutSel;
    logic [N-1:0]   fOutData, rOutData;
    logic           fOutValid, fOutLast, fOutReady, rOutValid, rOutLast, rOutReady;

    mux_arb_mto1 #(.N(N), .M(M), .S(3), .ARB_MODE(0)) dutFix (
        .clk(clk), .rst(rst), .in_data(fData), .in_valid(fValid), .in_last(fLast),
        .in_ready(fReady), .sel(fSel), .out_data(fOutData), .out_valid(fOutValid),
        .out_last(fOutLast), .out_sel(fOutSel), .out_ready(fOutReady)
    );

    mux_arb_mto1 #(.N(N), .M(M), .S(2), .ARB_MODE(1)) dutRr (
        .clk(clk), .rst(rst), .in_data(rData), .in_valid(rValid), .in_last(rLast),
        .in_ready(rReady), .sel(rSel), .out_data(rOutData), .out_valid(rOutValid),
        .out_last(rOutLast), .out_sel(rOutSel), .out_ready(rOutReady)
    );

    // Source beats are {last, data}; scoreboard entries are {sel[2:0], last, data}.
    logic [N:0]   fSrc [M][$];
    logic [N:0]   rSrc [M][$];
    logic [N+3:0] fExp [$];
    logic [N+3:0] rExp [$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus();
        logic [N:0] beat;
        for (int k = 0; k < M; k++) begin
            fValid[k] = fSrc[k].size() != 0;
            beat = fValid[k] ? fSrc[k][0] : '0;
            fData[N*k +: N] = beat[N-1:0];
            fLast[k] = beat[N];
            rValid[k] = rSrc[k].size() != 0;
            beat = rValid[k] ? rSrc[k][0] : '0;
            rData[N*k +: N] = beat[N-1:0];
            rLast[k] = beat[N];
        end
    endtask

    task automatic srcF(input int k, input logic last, input logic [N-1:0] d);
        fSrc[k].push_back({last, d});
    endtask

    task automatic srcR(input int k, input logic last, input logic [N-1:0] d);
        rSrc[k].push_back({last, d});
    endtask

    task automatic expF(input logic [2:0] s, input logic last, input logic [N-1:0] d);
        fExp.push_back({s, last, d});
    endtask

    task automatic expR(input logic [2:0] s, input logic last, input logic [N-1:0] d);
        rExp.push_back({s, last, d});
    endtask

    task automatic flushSources();
        for (int k = 0; k < M; k++) begin
            fSrc[k].delete();
            rSrc[k].delete();
        end
        applyStimulus();
    endtask

    // One clock: score accepted output beats at the negedge, then retire accepted source beats.
    task automatic tick();
        logic [M-1:0] fAcc, rAcc;
        @(negedge clk);
        if (fOutValid && fOutReady) begin
            if (fExp.size() == 0) checkOutput("fix_unexpected_beat", {fOutSel, fOutLast, fOutData}, 0);
            else checkOutput("fix_beat", {fOutSel, fOutLast, fOutData}, fExp.pop_front());
        end
        if (rOutValid && rOutReady) begin
            if (rExp.size() == 0) checkOutput("rr_unexpected_beat", {1'b0, rOutSel, rOutLast, rOutData}, 0);
            else checkOutput("rr_beat", {1'b0, rOutSel, rOutLast, rOutData}, rExp.pop_front());
        end
        fAcc = fValid & fReady;
        rAcc = rValid & rReady;
        @(posedge clk);
        #1;
        for (int k = 0; k < M; k++) begin
            if (fAcc[k]) void'(fSrc[k].pop_front());
            if (rAcc[k]) void'(rSrc[k].pop_front());
        end
        applyStimulus();
    endtask

    task automatic drain(input int maxCycles);
        int n = 0;
        while ((fExp.size() != 0 || rExp.size() != 0) && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("drain_remaining", fExp.size() + rExp.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        fSel = '0;
        rSel = '0;
        fOutReady = 1'b1;
        rOutReady = 1'b1;
        srcF(0, 1'b1, 8'hEE);
        applyStimulus();
        #1;
        checkOutput("rst_ready", fReady, 0);
        checkOutput("rst_out_valid", {fOutValid, rOutValid}, 0);
        checkOutput("rst_out_fields", {fOutData, fOutSel, fOutLast, rOutData, rOutSel, rOutLast}, 0);
        flushSources();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fixed select of a single-beat packet from input 2.
        fSel = 3'd2;
        srcF(2, 1'b1, 8'hA5);
        expF(2, 1'b1, 8'hA5);
        applyStimulus();
        #1;
        checkOutput("t1_in_ready", fReady, 4'b0100);
        tick();
        checkOutput("t1_out", {fOutValid, fOutSel, fOutLast, fOutData}, {1'b1, 3'd2, 1'b1, 8'hA5});
        drain(10);

        // Round-robin over four inputs, two single-beat packets each.
        for (int k = 0; k < M; k++) begin
            srcR(k, 1'b1, 8'h20 + 8'(k));
            srcR(k, 1'b1, 8'h30 + 8'(k));
        end
        for (int k = 0; k < M; k++) expR(3'(k), 1'b1, 8'h20 + 8'(k));
        for (int k = 0; k < M; k++) expR(3'(k), 1'b1, 8'h30 + 8'(k));
        applyStimulus();
        tick();
        for (int c = 0; c < 8; c++) begin
            checkOutput("t2_no_bubble", rOutValid, 1'b1);
            tick();
        end
        drain(10);

        // Multi-beat packet on input 1 locks out a persistently valid input 0.
        srcR(0, 1'b1, 8'hA0);
        srcR(0, 1'b1, 8'hB0);
        srcR(1, 1'b0, 8'h11);
        srcR(1, 1'b0, 8'h12);
        srcR(1, 1'b1, 8'h13);
        expR(0, 1'b1, 8'hA0);
        expR(1, 1'b0, 8'h11);
        expR(1, 1'b0, 8'h12);
        expR(1, 1'b1, 8'h13);
        expR(0, 1'b1, 8'hB0);
        applyStimulus();
        tick();
        tick();
        checkOutput("t3_lock_ready", rReady, 4'b0010);
        drain(20);

        // Backpressure while a beat from input 2 is presented.
        srcR(2, 1'b0, 8'h40);
        srcR(2, 1'b1, 8'h41);
        srcR(3, 1'b1, 8'h50);
        expR(2, 1'b0, 8'h40);
        expR(2, 1'b1, 8'h41);
        expR(3, 1'b1, 8'h50);
        applyStimulus();
        tick();
        rOutReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("t4_hold", {rOutValid, rOutSel, rOutLast, rOutData}, {1'b1, 2'd2, 1'b0, 8'h40});
            checkOutput("t4_in_ready", rReady, 0);
        end
        rOutReady = 1'b1;
        drain(20);

        // Out-of-range select never grants.
        fSel = 3'd5;
        for (int k = 0; k < M; k++) srcF(k, 1'b1, 8'hC0 + 8'(k));
        applyStimulus();
        #1;
        checkOutput("t5_sel_oor_ready", fReady, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("t5_sel_oor_valid", fOutValid, 1'b0);
        end
        flushSources();

        // Select change mid-packet is ignored until the last beat.
        fSel = 3'd1;
        srcF(1, 1'b0, 8'h61);
        srcF(1, 1'b0, 8'h62);
        srcF(1, 1'b1, 8'h63);
        srcF(3, 1'b1, 8'h70);
        expF(1, 1'b0, 8'h61);
        expF(1, 1'b0, 8'h62);
        expF(1, 1'b1, 8'h63);
        expF(3, 1'b1, 8'h70);
        applyStimulus();
        tick();
        fSel = 3'd3;
        #1;
        checkOutput("t5_lock_ready", fReady, 4'b0010);
        drain(20);

        // Reset mid-packet: move ptr to 2, lock on input 2, then reset between edges.
        srcR(1, 1'b1, 8'h15);
        expR(1, 1'b1, 8'h15);
        applyStimulus();
        drain(10);
        srcR(2, 1'b0, 8'h80);
        srcR(2, 1'b0, 8'h81);
        srcR(2, 1'b1, 8'h82);
        applyStimulus();
        tick();
        checkOutput("t6_pre_reset", {rOutValid, rOutSel, rOutData}, {1'b1, 2'd2, 8'h80});
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_valid", rOutValid, 1'b0);
        checkOutput("t6_async_ready", rReady, 0);
        rExp.delete();
        flushSources();
        @(posedge clk);
        #1;
        rst = 1'b0;
        srcR(0, 1'b1, 8'h91);
        srcR(1, 1'b1, 8'h90);
        srcR(3, 1'b1, 8'h92);
        expR(0, 1'b1, 8'h91);
        expR(1, 1'b1, 8'h90);
        expR(3, 1'b1, 8'h92);
        applyStimulus();
        drain(20);
        tick();
        checkOutput("final_idle", {fOutValid, rOutValid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
